// File: rtl/time_set_ctrl.sv
// Time-set UI controller: debounces mode/up/down buttons and runs the hour/minute/second
// edit FSM. Holds the timekeeper while editing and commits with one vblank-aligned load.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned BLINK_HALF      = 25000000,
  parameter int unsigned EDIT_TIMEOUT    = 1000000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       vblank,
  output logic [5:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic       hold,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam int unsigned BLK_W   = $clog2(BLINK_HALF + 1);
  localparam int unsigned IDLE_W  = $clog2(EDIT_TIMEOUT + 1);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0]  RPT_DLY  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0]  RPT_PER  = RPT_W'(REPEAT_PERIOD);
  localparam logic [BLK_W-1:0]  BLK_MAX  = BLK_W'(BLINK_HALF);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(EDIT_TIMEOUT);

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_HOUR   = 3'd1;
  localparam logic [2:0] ST_MIN    = 3'd2;
  localparam logic [2:0] ST_SEC    = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  // Button vectors are ordered {down, up, mode}.
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       lvl_q, lvl_d;
  logic [2:0]       ev_q, ev_d;
  logic [DB_W-1:0]  db_cnt_q [3];
  logic [DB_W-1:0]  db_cnt_d [3];
  logic [RPT_W-1:0] rpt_cnt_q [2];
  logic [RPT_W-1:0] rpt_cnt_d [2];
  logic [1:0]       rpt_on_q, rpt_on_d;

  logic [2:0]        state_q, state_d;
  logic [5:0]        set_hour_q, set_hour_d;
  logic [5:0]        set_min_q, set_min_d;
  logic [5:0]        set_sec_q, set_sec_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;

  logic mode_ev, up_ev, dn_ev, any_ev, editing;

  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] top,
                                            input logic inc);
    if (inc) return (v >= top) ? 6'd0 : v + 6'd1;
    return (v == 6'd0 || v > top) ? top : v - 6'd1;
  endfunction

  always_comb begin : debounce
    for (int i = 0; i < 3; i++) begin
      lvl_d[i]    = lvl_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) lvl_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Press events plus auto-repeat for up/down; a release drops the repeat state at once.
  always_comb begin : auto_repeat
    ev_d[0] = lvl_d[0] & ~lvl_q[0];
    for (int j = 0; j < 2; j++) begin
      ev_d[j+1]    = lvl_d[j+1] & ~lvl_q[j+1];
      rpt_cnt_d[j] = '0;
      rpt_on_d[j]  = 1'b0;
      if (lvl_q[j+1] && lvl_d[j+1]) begin
        rpt_on_d[j]  = rpt_on_q[j];
        rpt_cnt_d[j] = rpt_cnt_q[j] + 1'b1;
        if ((!rpt_on_q[j] && rpt_cnt_d[j] == RPT_DLY) ||
            ( rpt_on_q[j] && rpt_cnt_d[j] == RPT_PER)) begin
          ev_d[j+1]    = 1'b1;
          rpt_on_d[j]  = 1'b1;
          rpt_cnt_d[j] = '0;
        end
      end
    end
  end

  assign mode_ev = ev_q[0];
  assign up_ev   = !ev_q[0] && ev_q[1] && !ev_q[2];
  assign dn_ev   = !ev_q[0] && ev_q[2] && !ev_q[1];
  assign any_ev  = |ev_q;
  assign editing = (state_q == ST_HOUR) || (state_q == ST_MIN) || (state_q == ST_SEC);

  always_comb begin : edit_fsm
    state_d     = state_q;
    set_hour_d  = set_hour_q;
    set_min_d   = set_min_q;
    set_sec_d   = set_sec_q;
    idle_d      = '0;
    blink_cnt_d = '0;
    blink_d     = 1'b0;

    if (editing) begin
      if (any_ev) begin
        idle_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
        if (idle_d == IDLE_MAX) state_d = ST_RUN;
      end
      if (up_ev || dn_ev) begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
        if (blink_cnt_d == BLK_MAX) begin
          blink_cnt_d = '0;
          blink_d     = ~blink_q;
        end
      end
    end

    case (state_q)
      ST_RUN: begin
        if (mode_ev) begin
          set_hour_d = cur_hour;
          set_min_d  = cur_min;
          set_sec_d  = cur_sec;
          state_d    = ST_HOUR;
        end
      end
      ST_HOUR: begin
        if (mode_ev) state_d = ST_MIN;
        else if (up_ev || dn_ev) set_hour_d = step_field(set_hour_q, 6'd23, up_ev);
      end
      ST_MIN: begin
        if (mode_ev) state_d = ST_SEC;
        else if (up_ev || dn_ev) set_min_d = step_field(set_min_q, 6'd59, up_ev);
      end
      ST_SEC: begin
        if (mode_ev) state_d = ST_COMMIT;
        else if (up_ev || dn_ev) set_sec_d = step_field(set_sec_q, 6'd59, up_ev);
      end
      ST_COMMIT: begin
        if (vblank) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Every state entry restarts the idle timer and shows the new field unblanked.
    if (state_d != state_q) begin
      idle_d      = '0;
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      lvl_q       <= '0;
      ev_q        <= '0;
      rpt_on_q    <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      for (int j = 0; j < 2; j++) rpt_cnt_q[j] <= '0;
      state_q     <= ST_RUN;
      set_hour_q  <= '0;
      set_min_q   <= '0;
      set_sec_q   <= '0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      sync1_q     <= {btn_down, btn_up, btn_mode};
      sync2_q     <= sync1_q;
      lvl_q       <= lvl_d;
      ev_q        <= ev_d;
      rpt_on_q    <= rpt_on_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int j = 0; j < 2; j++) rpt_cnt_q[j] <= rpt_cnt_d[j];
      state_q     <= state_d;
      set_hour_q  <= set_hour_d;
      set_min_q   <= set_min_d;
      set_sec_q   <= set_sec_d;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  always_comb begin : field_decode
    edit_field = 2'd0;
    case (state_q)
      ST_HOUR: edit_field = 2'd1;
      ST_MIN:  edit_field = 2'd2;
      ST_SEC:  edit_field = 2'd3;
      default: edit_field = 2'd0;
    endcase
  end

  assign load     = (state_q == ST_COMMIT) && vblank;
  assign hold     = (state_q != ST_RUN);
  assign blink    = blink_q;
  assign set_hour = set_hour_q;
  assign set_min  = set_min_q;
  assign set_sec  = set_sec_q;

endmodule
